reg_write_arbiter: RTL and testbench

REG_WRITE_ARBITER -- requirements
Module: reg_write_arbiter

---
 rtl/reg_write_arbiter_if.sv | 33 +++
 rtl/reg_write_arbiter.sv | 154 +++++++++++++++
 tb/tb_reg_write_arbiter.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/reg_write_arbiter_if.sv
// Handshake and register-file write bus between two write requesters and the arbiter.
// The master side drives the requests and observes grants, writes and status.
interface reg_write_arbiter_if;
    logic       req0_valid;
    logic [2:0] req0_num;
    logic [7:0] req0_data;
    logic       req0_ready;
    logic       req1_valid;
    logic [2:0] req1_num;
    logic [7:0] req1_data;
    logic       req1_ready;
    logic       writeReg;
    logic [2:0] write_reg_num;
    logic [7:0] write_data;
    logic       init_done;
    logic [7:0] contend_cnt;

    modport master (
        output req0_valid, req0_num, req0_data,
        output req1_valid, req1_num, req1_data,
        input  req0_ready, req1_ready,
        input  writeReg, write_reg_num, write_data,
        input  init_done, contend_cnt
    );

    modport slave (
        input  req0_valid, req0_num, req0_data,
        input  req1_valid, req1_num, req1_data,
        output req0_ready, req1_ready,
        output writeReg, write_reg_num, write_data,
        output init_done, contend_cnt
    );
endinterface

// File: rtl/reg_write_arbiter.sv
// Two-requester round-robin write arbiter for an 8x8 register file. After reset it
// sweeps every register to its own index, then serves writeback/load writes one per cycle.
module reg_write_arbiter (
    input logic                clk,
    input logic                rst,
    reg_write_arbiter_if.slave bus
);
    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t     state_r;
    state_t     state_nxt_s;
    logic [2:0] cnt_r;
    logic       prio_r;
    logic       we_r;
    logic [2:0] num_r;
    logic [7:0] data_r;
    logic       init_done_r;
    logic [7:0] contend_r;
    logic       both_s;
    logic       ready0_s;
    logic       ready1_s;
    logic       xfer0_s;
    logic       xfer1_s;

    assign both_s  = bus.req0_valid & bus.req1_valid;
    assign xfer0_s = bus.req0_valid & ready0_s;
    assign xfer1_s = bus.req1_valid & ready1_s;

    // Next-state: the sweep hands over to RUN on the edge that writes register 7.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_INIT: begin
                if (cnt_r == 3'd7) begin
                    state_nxt_s = ST_RUN;
                end else begin
                    state_nxt_s = ST_INIT;
                end
            end
            ST_RUN:  state_nxt_s = ST_RUN;
            default: state_nxt_s = ST_INIT;
        endcase
    end

    // Grant logic: a lone requester always wins, contention is settled by prio_r.
    always_comb begin
        ready0_s = 1'b0;
        ready1_s = 1'b0;
        if (state_r == ST_RUN) begin
            if (both_s) begin
                ready0_s = ~prio_r;
                ready1_s = prio_r;
            end else begin
                ready0_s = bus.req0_valid;
                ready1_s = bus.req1_valid;
            end
        end else begin
            ready0_s = 1'b0;
            ready1_s = 1'b0;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_INIT;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Sweep counter, only advances during the initialisation sweep.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_r <= 3'd0;
        end else if (state_r == ST_INIT) begin
            cnt_r <= cnt_r + 3'd1;
        end else begin
            cnt_r <= cnt_r;
        end
    end

    // Register-file write port: sweep writes, then the granted requester one cycle later.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            we_r   <= 1'b0;
            num_r  <= 3'd0;
            data_r <= 8'd0;
        end else begin
            case (state_r)
                ST_INIT: begin
                    we_r   <= 1'b1;
                    num_r  <= cnt_r;
                    data_r <= {5'b00000, cnt_r};
                end
                ST_RUN: begin
                    if (xfer0_s) begin
                        we_r   <= 1'b1;
                        num_r  <= bus.req0_num;
                        data_r <= bus.req0_data;
                    end else if (xfer1_s) begin
                        we_r   <= 1'b1;
                        num_r  <= bus.req1_num;
                        data_r <= bus.req1_data;
                    end else begin
                        we_r <= 1'b0;
                    end
                end
                default: begin
                    we_r <= 1'b0;
                end
            endcase
        end
    end

    // Round-robin pointer: after a grant the other requester gets first claim.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prio_r <= 1'b0;
        end else if (xfer0_s) begin
            prio_r <= 1'b1;
        end else if (xfer1_s) begin
            prio_r <= 1'b0;
        end else begin
            prio_r <= prio_r;
        end
    end

    // Status: sticky init_done and saturating contention counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            init_done_r <= 1'b0;
            contend_r   <= 8'd0;
        end else begin
            init_done_r <= (state_nxt_s == ST_RUN);
            if ((state_r == ST_RUN) && both_s && (contend_r != 8'hFF)) begin
                contend_r <= contend_r + 8'd1;
            end else begin
                contend_r <= contend_r;
            end
        end
    end

    assign bus.req0_ready    = ready0_s;
    assign bus.req1_ready    = ready1_s;
    assign bus.writeReg      = we_r;
    assign bus.write_reg_num = num_r;
    assign bus.write_data    = data_r;
    assign bus.init_done     = init_done_r;
    assign bus.contend_cnt   = contend_r;
endmodule

// File: tb/tb_reg_write_arbiter.sv
// Directed bench for reg_write_arbiter: vector table for RUN arbitration plus
// hand-written sweep, reset and saturation sequences.
module tb_reg_write_arbiter;
    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;
    logic [7:0] rf [0:7];

    reg_write_arbiter_if bus ();

    reg_write_arbiter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    // Register-file sink fed by the write port.
    always @(posedge clk) begin
        if (bus.writeReg === 1'b1) begin
            rf[bus.write_reg_num] <= bus.write_data;
        end
    end

    typedef struct {
        logic       v0;
        logic [2:0] n0;
        logic [7:0] d0;
        logic       v1;
        logic [2:0] n1;
        logic [7:0] d1;
        logic       r0;
        logic       r1;
        logic       we;
        logic [2:0] num;
        logic [7:0] data;
        logic [7:0] cc;
    } vec_t;

    vec_t vecs [12];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v0, input logic [2:0] n0, input logic [7:0] d0,
                         input logic v1, input logic [2:0] n1, input logic [7:0] d1);
        bus.req0_valid = v0;
        bus.req0_num   = n0;
        bus.req0_data  = d0;
        bus.req1_valid = v1;
        bus.req1_num   = n1;
        bus.req1_data  = d1;
    endtask

    // Release reset and check the 8-cycle sweep with both valids held for most of it.
    task automatic release_and_sweep(input string tag);
        drive(1'b1, 3'd6, 8'h66, 1'b1, 3'd7, 8'h77);
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk($sformatf("%s_we%0d", tag, i), {31'd0, bus.writeReg}, 32'd1);
            chk($sformatf("%s_num%0d", tag, i), {29'd0, bus.write_reg_num}, i);
            chk($sformatf("%s_data%0d", tag, i), {24'd0, bus.write_data}, i);
            chk($sformatf("%s_done%0d", tag, i), {31'd0, bus.init_done}, (i == 7) ? 32'd1 : 32'd0);
            if (i < 7) begin
                chk($sformatf("%s_rdy%0d", tag, i), {30'd0, bus.req0_ready, bus.req1_ready}, 32'd0);
            end
            if (i == 6) begin
                drive(1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 8'h00);
            end
        end
        chk($sformatf("%s_cc", tag), {24'd0, bus.contend_cnt}, 32'd0);
    endtask

    initial begin
        int g0;
        int g1;
        clk     = 1'b0;
        rst     = 1'b0;
        n_tests = 0;
        n_fail  = 0;
        drive(1'b1, 3'd1, 8'h01, 1'b1, 3'd2, 8'h02);

        //                v0   n0    d0     v1   n1    d1     r0   r1   we   num   data   cc
        vecs[0]  = '{1'b1, 3'd3, 8'hA5, 1'b0, 3'd0, 8'h00, 1'b1, 1'b0, 1'b1, 3'd3, 8'hA5, 8'd0};
        vecs[1]  = '{1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 1'b0, 3'd3, 8'hA5, 8'd0};
        vecs[2]  = '{1'b0, 3'd0, 8'h00, 1'b1, 3'd6, 8'h3C, 1'b0, 1'b1, 1'b1, 3'd6, 8'h3C, 8'd0};
        vecs[3]  = '{1'b1, 3'd1, 8'h10, 1'b1, 3'd2, 8'h20, 1'b1, 1'b0, 1'b1, 3'd1, 8'h10, 8'd1};
        vecs[4]  = '{1'b1, 3'd4, 8'h40, 1'b1, 3'd2, 8'h20, 1'b0, 1'b1, 1'b1, 3'd2, 8'h20, 8'd2};
        vecs[5]  = '{1'b1, 3'd4, 8'h40, 1'b1, 3'd7, 8'h70, 1'b1, 1'b0, 1'b1, 3'd4, 8'h40, 8'd3};
        vecs[6]  = '{1'b1, 3'd0, 8'h01, 1'b1, 3'd7, 8'h70, 1'b0, 1'b1, 1'b1, 3'd7, 8'h70, 8'd4};
        vecs[7]  = '{1'b1, 3'd0, 8'h01, 1'b0, 3'd0, 8'h00, 1'b1, 1'b0, 1'b1, 3'd0, 8'h01, 8'd4};
        vecs[8]  = '{1'b1, 3'd5, 8'h11, 1'b1, 3'd5, 8'h22, 1'b0, 1'b1, 1'b1, 3'd5, 8'h22, 8'd5};
        vecs[9]  = '{1'b1, 3'd5, 8'h11, 1'b0, 3'd0, 8'h00, 1'b1, 1'b0, 1'b1, 3'd5, 8'h11, 8'd5};
        vecs[10] = '{1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 1'b0, 3'd5, 8'h11, 8'd5};
        vecs[11] = '{1'b1, 3'd2, 8'hAA, 1'b1, 3'd3, 8'hBB, 1'b0, 1'b1, 1'b1, 3'd3, 8'hBB, 8'd6};

        // Reset state while held low, with both requesters asking.
        #12;
        chk("rst_we",   {31'd0, bus.writeReg}, 32'd0);
        chk("rst_num",  {29'd0, bus.write_reg_num}, 32'd0);
        chk("rst_data", {24'd0, bus.write_data}, 32'd0);
        chk("rst_done", {31'd0, bus.init_done}, 32'd0);
        chk("rst_cc",   {24'd0, bus.contend_cnt}, 32'd0);
        chk("rst_rdy",  {30'd0, bus.req0_ready, bus.req1_ready}, 32'd0);
        @(posedge clk);
        #1;
        chk("rst_hold_we", {31'd0, bus.writeReg}, 32'd0);

        release_and_sweep("sweep0");

        // Table-driven arbitration in RUN.
        for (int k = 0; k < 12; k++) begin
            drive(vecs[k].v0, vecs[k].n0, vecs[k].d0, vecs[k].v1, vecs[k].n1, vecs[k].d1);
            #1;
            chk($sformatf("v%0d_r0", k), {31'd0, bus.req0_ready}, {31'd0, vecs[k].r0});
            chk($sformatf("v%0d_r1", k), {31'd0, bus.req1_ready}, {31'd0, vecs[k].r1});
            tick();
            chk($sformatf("v%0d_we", k),   {31'd0, bus.writeReg}, {31'd0, vecs[k].we});
            chk($sformatf("v%0d_num", k),  {29'd0, bus.write_reg_num}, {29'd0, vecs[k].num});
            chk($sformatf("v%0d_data", k), {24'd0, bus.write_data}, {24'd0, vecs[k].data});
            chk($sformatf("v%0d_cc", k),   {24'd0, bus.contend_cnt}, {24'd0, vecs[k].cc});
        end
        drive(1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 8'h00);
        tick();
        tick();
        chk("rf5_last_wins", {24'd0, rf[5]}, 32'h11);
        chk("rf6",           {24'd0, rf[6]}, 32'h3C);
        chk("rf3",           {24'd0, rf[3]}, 32'hBB);
        chk("rf1",           {24'd0, rf[1]}, 32'h10);

        // Reset in the middle of the sweep (after register 3 was written, cnt=4).
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
        end
        chk("midinit_num3", {29'd0, bus.write_reg_num}, 32'd3);
        drive(1'b1, 3'd2, 8'h5A, 1'b1, 3'd4, 8'h4B);
        rst = 1'b0;
        #1;
        chk("midinit_we",   {31'd0, bus.writeReg}, 32'd0);
        chk("midinit_num",  {29'd0, bus.write_reg_num}, 32'd0);
        chk("midinit_rdy",  {30'd0, bus.req0_ready, bus.req1_ready}, 32'd0);
        tick();
        chk("midinit_we2",  {31'd0, bus.writeReg}, 32'd0);
        chk("midinit_rdy2", {30'd0, bus.req0_ready, bus.req1_ready}, 32'd0);
        release_and_sweep("sweep1");

        // Reset in RUN while a transfer is pending: the write must be dropped.
        drive(1'b1, 3'd2, 8'hAA, 1'b0, 3'd0, 8'h00);
        #1;
        chk("runrst_r0", {31'd0, bus.req0_ready}, 32'd1);
        #1;
        rst = 1'b0;
        #1;
        chk("runrst_we",   {31'd0, bus.writeReg}, 32'd0);
        chk("runrst_done", {31'd0, bus.init_done}, 32'd0);
        chk("runrst_rdy",  {30'd0, bus.req0_ready, bus.req1_ready}, 32'd0);
        tick();
        chk("runrst_we2",   {31'd0, bus.writeReg}, 32'd0);
        chk("runrst_num2",  {29'd0, bus.write_reg_num}, 32'd0);
        chk("runrst_data2", {24'd0, bus.write_data}, 32'd0);
        release_and_sweep("sweep2");

        // Sustained contention: strict alternation and a saturating counter.
        g0 = 0;
        g1 = 0;
        drive(1'b1, 3'd1, 8'h11, 1'b1, 3'd2, 8'h22);
        for (int k = 0; k < 300; k++) begin
            #1;
            chk($sformatf("sat%0d_r0", k), {31'd0, bus.req0_ready}, (k % 2 == 0) ? 32'd1 : 32'd0);
            chk($sformatf("sat%0d_r1", k), {31'd0, bus.req1_ready}, (k % 2 == 1) ? 32'd1 : 32'd0);
            if (bus.req0_ready === 1'b1) g0++;
            if (bus.req1_ready === 1'b1) g1++;
            tick();
            chk($sformatf("sat%0d_we", k),  {31'd0, bus.writeReg}, 32'd1);
            chk($sformatf("sat%0d_num", k), {29'd0, bus.write_reg_num}, (k % 2 == 0) ? 32'd1 : 32'd2);
            chk($sformatf("sat%0d_cc", k),  {24'd0, bus.contend_cnt}, (k + 1 < 255) ? (k + 1) : 255);
        end
        chk("sat_g0", g0, 32'd150);
        chk("sat_g1", g1, 32'd150);
        drive(1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 8'h00);
        tick();
        chk("sat_idle_we", {31'd0, bus.writeReg}, 32'd0);
        chk("sat_final_cc", {24'd0, bus.contend_cnt}, 32'hFF);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
